// File: rtl/demo_scene_sequencer_if.sv
// demo_scene_sequencer_if: control bundle between the frame scheduler and its
// user. The master side drives frame_tick/pause/skip and observes the per-frame
// control values; the slave side (the sequencer) does the opposite.
interface demo_scene_sequencer_if;
  logic       frame_tick;
  logic       pause;
  logic       skip;
  logic [1:0] scene;
  logic [7:0] scene_frame;
  logic [9:0] scroll_x;
  logic [1:0] fade;
  logic       transition;

  modport master (
    output frame_tick, pause, skip,
    input  scene, scene_frame, scroll_x, fade, transition
  );

  modport slave (
    input  frame_tick, pause, skip,
    output scene, scene_frame, scroll_x, fade, transition
  );
endinterface

// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: frame-rate scheduler for the VGA demoscene datapath.
// Counts frame ticks, steps through NUM_SCENES scenes and produces registered
// per-frame control values (scene, scene_frame, scroll_x, fade, transition),
// which therefore only move on frame boundaries.
// Build option FADE_EN: when defined, scene changes run a FADE_OUT/FADE_IN
// brightness sequence; when undefined, scenes cut on the transition tick and
// fade/transition are constant (3 and 0).
module demo_scene_sequencer #(
  parameter int NUM_SCENES   = 4,
  parameter int SCENE_FRAMES = 240,
  parameter int FADE_STEP    = 4,
  parameter int SCROLL_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  demo_scene_sequencer_if.slave io_bus
);

  // Parameter range guards: an out-of-range value elaborates a named, empty
  // scope that stands out in the elaborated hierarchy.
  if (NUM_SCENES < 1 || NUM_SCENES > 4) begin : g_bad_num_scenes
  end
  if (SCENE_FRAMES < 2 || SCENE_FRAMES > 255) begin : g_bad_scene_frames
  end
  if (FADE_STEP < 1 || FADE_STEP > 16) begin : g_bad_fade_step
  end
  if (SCROLL_STEP < 0 || SCROLL_STEP > 1023) begin : g_bad_scroll_step
  end

  localparam logic [1:0] LAST_SCENE = 2'(NUM_SCENES - 1);
  localparam logic [7:0] LAST_FRAME = 8'(SCENE_FRAMES - 1);
  localparam logic [9:0] SCROLL_INC = 10'(SCROLL_STEP);

  logic [1:0] r_scene,        w_scene_nxt;
  logic [7:0] r_scene_frame,  w_scene_frame_nxt;
  logic [9:0] r_scroll_x,     w_scroll_x_nxt;
  logic       r_skip_pending, w_skip_pending_nxt;

  logic       w_tick;       // frame tick that is not masked by pause
  logic       w_in_run;     // sequencer is showing a scene (not fading)
  logic       w_skip_latch; // skip request to remember until the next tick
  logic       w_end_scene;  // a tick in RUN now would start a transition
  logic [1:0] w_scene_adv;  // scene index after the next advance

  assign w_tick       = io_bus.frame_tick & ~io_bus.pause;
  assign w_skip_latch = w_in_run & io_bus.skip & ~io_bus.pause;
  assign w_end_scene  = (r_scene_frame == LAST_FRAME) | r_skip_pending | io_bus.skip;
  assign w_scene_adv  = (r_scene == LAST_SCENE) ? 2'd0 : r_scene + 2'd1;

`ifdef FADE_EN
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FADE_OUT = 2'd1,
    S_FADE_IN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'(FADE_STEP - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_step,       w_step_nxt;
  logic [1:0] r_fade,       w_fade_nxt;
  logic       r_transition, w_transition_nxt;
  logic       w_step_last;

  assign w_in_run    = (r_state == S_RUN);
  assign w_step_last = (r_step == LAST_STEP);

  // State register: back to RUN on reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: the FSM only moves on an unpaused frame tick.
  always_comb begin
    // NOTE: a default assignment before any branch keeps this block free of
    // inferred latches.
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        S_RUN:      if (w_end_scene)                   w_state_nxt = S_FADE_OUT;
        S_FADE_OUT: if (w_step_last && r_fade == 2'd0) w_state_nxt = S_FADE_IN;
        S_FADE_IN:  if (w_step_last && r_fade == 2'd2) w_state_nxt = S_RUN;
        default:                                       w_state_nxt = S_RUN;
      endcase
    end
  end
`else
  assign w_in_run = 1'b1;
`endif

  // Output/datapath decode: next values of all per-frame control registers.
  always_comb begin
    w_scene_nxt        = r_scene;
    w_scene_frame_nxt  = r_scene_frame;
    w_scroll_x_nxt     = r_scroll_x;
    w_skip_pending_nxt = r_skip_pending;
`ifdef FADE_EN
    w_step_nxt         = r_step;
    w_fade_nxt         = r_fade;
    w_transition_nxt   = r_transition;
`endif

    if (w_skip_latch) w_skip_pending_nxt = 1'b1;

    if (w_tick) begin
      // Scroll keeps moving through fades too; 10-bit wrap is natural.
      w_scroll_x_nxt = r_scroll_x + SCROLL_INC;
`ifdef FADE_EN
      case (r_state)
        S_RUN: begin
          if (w_end_scene) begin
            // Transition start: scene_frame and fade hold their values.
            w_skip_pending_nxt = 1'b0;
            w_step_nxt         = 4'd0;
            w_transition_nxt   = 1'b1;
          end else begin
            w_scene_frame_nxt = r_scene_frame + 8'd1;
          end
        end
        S_FADE_OUT: begin
          if (w_step_last) begin
            w_step_nxt = 4'd0;
            if (r_fade == 2'd0) begin
              w_scene_nxt       = w_scene_adv;
              w_scene_frame_nxt = 8'd0;
            end else begin
              w_fade_nxt = r_fade - 2'd1;
            end
          end else begin
            w_step_nxt = r_step + 4'd1;
          end
        end
        S_FADE_IN: begin
          w_scene_frame_nxt = r_scene_frame + 8'd1;
          if (w_step_last) begin
            w_step_nxt = 4'd0;
            w_fade_nxt = r_fade + 2'd1;
            if (r_fade == 2'd2) w_transition_nxt = 1'b0;
          end else begin
            w_step_nxt = r_step + 4'd1;
          end
        end
        default: ;
      endcase
`else
      if (w_end_scene) begin
        // Hard cut: the new scene starts on this very tick.
        w_skip_pending_nxt = 1'b0;
        w_scene_nxt        = w_scene_adv;
        w_scene_frame_nxt  = 8'd0;
      end else begin
        w_scene_frame_nxt = r_scene_frame + 8'd1;
      end
`endif
    end
  end

  // Datapath registers: reset wins over any tick or skip in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scene        <= 2'd0;
      r_scene_frame  <= 8'd0;
      r_scroll_x     <= 10'd0;
      r_skip_pending <= 1'b0;
`ifdef FADE_EN
      r_step         <= 4'd0;
      r_fade         <= 2'd3;
      r_transition   <= 1'b0;
`endif
    end else begin
      r_scene        <= w_scene_nxt;
      r_scene_frame  <= w_scene_frame_nxt;
      r_scroll_x     <= w_scroll_x_nxt;
      r_skip_pending <= w_skip_pending_nxt;
`ifdef FADE_EN
      r_step         <= w_step_nxt;
      r_fade         <= w_fade_nxt;
      r_transition   <= w_transition_nxt;
`endif
    end
  end

  assign io_bus.scene       = r_scene;
  assign io_bus.scene_frame = r_scene_frame;
  assign io_bus.scroll_x    = r_scroll_x;
`ifdef FADE_EN
  assign io_bus.fade        = r_fade;
  assign io_bus.transition  = r_transition;
`else
  assign io_bus.fade        = 2'd3;
  assign io_bus.transition  = 1'b0;
`endif

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// tb_demo_scene_sequencer: directed, table-driven bench for demo_scene_sequencer
// with NUM_SCENES=4, SCENE_FRAMES=8, FADE_STEP=2, SCROLL_STEP=3. Expected values
// follow the FADE_EN setting the bench is compiled with.
module tb_demo_scene_sequencer;
  localparam int NUM_SCENES   = 4;
  localparam int SCENE_FRAMES = 8;
  localparam int FADE_STEP    = 2;
  localparam int SCROLL_STEP  = 3;

  logic clk = 1'b0;
  logic reset;

  demo_scene_sequencer_if bus ();

  demo_scene_sequencer #(
    .NUM_SCENES  (NUM_SCENES),
    .SCENE_FRAMES(SCENE_FRAMES),
    .FADE_STEP   (FADE_STEP),
    .SCROLL_STEP (SCROLL_STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tick;
    logic       skip;
    logic       pause;
    logic [1:0] scene;
    logic [7:0] frame;
    logic [9:0] scroll;
    logic [1:0] fade;
    logic       trans;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] sc, input logic [7:0] fr,
                           input logic [9:0] sx, input logic [1:0] fd, input logic tr);
    check({tag, ".scene"},       32'(bus.scene),       32'(sc));
    check({tag, ".scene_frame"}, 32'(bus.scene_frame), 32'(fr));
    check({tag, ".scroll_x"},    32'(bus.scroll_x),    32'(sx));
    check({tag, ".fade"},        32'(bus.fade),        32'(fd));
    check({tag, ".transition"},  32'(bus.transition),  32'(tr));
  endtask

  // One clock cycle of stimulus: drive at negedge, sample 1 time unit after posedge.
  task automatic cyc(input logic r, input logic t, input logic s, input logic p);
    @(negedge clk);
    reset          = r;
    bus.frame_tick = t;
    bus.skip       = s;
    bus.pause      = p;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.skip       = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic add(input logic r, input logic t, input logic s, input logic p,
                     input logic [1:0] sc, input logic [7:0] fr, input logic [9:0] sx,
                     input logic [1:0] fd, input logic tr);
    vec_t v;
    v.rst = r; v.tick = t; v.skip = s; v.pause = p;
    v.scene = sc; v.frame = fr; v.scroll = sx; v.fade = fd; v.trans = tr;
    vecs.push_back(v);
  endtask

  initial begin
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.skip       = 1'b0;
    bus.pause      = 1'b0;

    // ---------------- vector table: rst tick skip pause | scene frame scroll fade trans
`ifdef FADE_EN
    add(1,0,0,0, 0,0, 0,3,0);
    for (int k = 1; k <= 7; k++) add(0,1,0,0, 0,8'(k),10'(3*k),3,0);
    add(0,1,0,0, 0,7,24,3,1);   // tick 8: transition starts, fade held
    add(0,1,0,0, 0,7,27,3,1);
    add(0,1,0,0, 0,7,30,2,1);   // tick 10
    add(0,1,0,0, 0,7,33,2,1);
    add(0,1,0,0, 0,7,36,1,1);   // tick 12
    add(0,1,0,0, 0,7,39,1,1);
    add(0,1,0,0, 0,7,42,0,1);   // tick 14
    add(0,1,0,0, 0,7,45,0,1);
    add(0,1,0,0, 1,0,48,0,1);   // tick 16: scene advances, FADE_IN
    add(0,1,0,0, 1,1,51,0,1);
    add(0,1,0,0, 1,2,54,1,1);
    add(0,1,0,0, 1,3,57,1,1);
    add(0,1,0,0, 1,4,60,2,1);
    add(0,1,0,0, 1,5,63,2,1);
    add(0,1,0,0, 1,6,66,3,0);   // tick 22: back to RUN
    add(0,1,0,0, 1,7,69,3,0);
    // skip sequence from a fresh reset
    add(1,0,0,0, 0,0, 0,3,0);
    add(0,1,0,0, 0,1, 3,3,0);
    add(0,1,0,0, 0,2, 6,3,0);
    add(0,0,1,0, 0,2, 6,3,0);   // skip latched, nothing moves
    add(0,1,0,0, 0,2, 9,3,1);   // transition starts, scene_frame holds at 2
    add(0,1,1,0, 0,2,12,3,1);   // skip in FADE_OUT ignored
    add(0,0,1,0, 0,2,12,3,1);
    add(0,1,0,0, 0,2,15,2,1);
    add(0,1,0,0, 0,2,18,2,1);
    add(0,1,0,0, 0,2,21,1,1);
    add(0,1,0,0, 0,2,24,1,1);
    add(0,1,0,0, 0,2,27,0,1);
    add(0,1,0,0, 0,2,30,0,1);
    add(0,1,0,0, 1,0,33,0,1);   // exactly one scene advance
    add(0,1,0,0, 1,1,36,0,1);
    add(0,1,0,0, 1,2,39,1,1);
    add(0,0,1,0, 1,2,39,1,1);   // skip in FADE_IN ignored
    add(0,1,0,0, 1,3,42,1,1);
    add(0,1,0,0, 1,4,45,2,1);
    add(0,1,0,0, 1,5,48,2,1);
    add(0,1,0,0, 1,6,51,3,0);
    add(0,1,0,0, 1,7,54,3,0);   // no stale skip: still in RUN
    add(0,1,0,1, 1,7,54,3,0);   // paused tick dropped
`else
    add(1,0,0,0, 0,0, 0,3,0);
    for (int k = 1; k <= 7; k++) add(0,1,0,0, 0,8'(k),10'(3*k),3,0);
    add(0,0,0,0, 0,7,21,3,0);   // idle cycle holds
    add(0,1,0,0, 1,0,24,3,0);   // tick 8: hard cut to scene 1
    add(0,1,0,0, 1,1,27,3,0);
    add(0,1,0,0, 1,2,30,3,0);
    add(0,0,1,0, 1,2,30,3,0);   // skip latched, nothing moves
    add(0,0,0,0, 1,2,30,3,0);
    add(0,1,0,0, 2,0,33,3,0);   // pending skip ends the scene
    add(0,1,0,0, 2,1,36,3,0);
    add(0,1,1,0, 3,0,39,3,0);   // skip on the tick cycle
    add(0,1,0,1, 3,0,39,3,0);   // paused tick dropped
    add(0,0,0,1, 3,0,39,3,0);
    add(0,1,0,0, 3,1,42,3,0);
    add(1,1,1,0, 0,0, 0,3,0);   // reset beats tick and skip
    add(0,1,0,0, 0,1, 3,3,0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].tick, vecs[i].skip, vecs[i].pause);
      check_all($sformatf("vec%0d", i), vecs[i].scene, vecs[i].frame,
                vecs[i].scroll, vecs[i].fade, vecs[i].trans);
    end

    // ---------------- scene index wrap after a full cycle of scenes
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FADE_EN
    ticks(64);
    check_all("wrap", 2'd0, 8'd0, 10'd192, 2'd0, 1'b1);
`else
    ticks(32);
    check_all("wrap", 2'd0, 8'd0, 10'd96, 2'd3, 1'b0);
`endif

    // ---------------- scroll_x modulo-1024 wrap: 342*3 = 1026
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(342);
    check("scroll_wrap.scroll_x", 32'(bus.scroll_x), 32'd2);
`ifndef FADE_EN
    check("scroll_wrap.scene",       32'(bus.scene),       32'd2);
    check("scroll_wrap.scene_frame", 32'(bus.scene_frame), 32'd6);
`endif

    // ---------------- pause across 50 ticks freezes everything
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    check_all("pre_pause", 2'd0, 8'd5, 10'd15, 2'd3, 1'b0);
    repeat (25) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_all("pause25", 2'd0, 8'd5, 10'd15, 2'd3, 1'b0);
    repeat (25) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_all("pause50", 2'd0, 8'd5, 10'd15, 2'd3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("resume", 2'd0, 8'd6, 10'd18, 2'd3, 1'b0);

    // ---------------- reset in the middle of a scene change, with tick and skip
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef FADE_EN
    ticks(18);
    check_all("pre_reset", 2'd1, 8'd2, 10'd54, 2'd1, 1'b1);
`else
    ticks(13);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("pre_reset", 2'd1, 8'd5, 10'd39, 2'd3, 1'b0);
`endif
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("mid_reset", 2'd0, 8'd0, 10'd0, 2'd3, 1'b0);
    ticks(1);
    check_all("post_reset", 2'd0, 8'd1, 10'd3, 2'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
